// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an on-chip word array: independent read and write burst engines,
// one outstanding burst per direction, INCR only.
module axi_mem_responder #(
  parameter int C_AXI_WIDTH      = 64,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_DEPTH      = 1024,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_AXI_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_AXI_WIDTH-1:0]        s_axi_wdata,
  input  logic [C_AXI_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready
);

  localparam int AW     = C_AXI_ADDR_WIDTH;
  localparam int B      = C_AXI_WIDTH / 8;
  localparam int LOG2B  = $clog2(B);
  localparam int MEM_AW = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;
  localparam logic [2:0]    SIZE  = 3'(LOG2B);
  localparam logic [AW-1:0] STEP  = AW'(B);
  localparam logic [AW:0]   LIMIT = (AW + 1)'(C_MEM_DEPTH) << LOG2B;

  typedef enum logic       {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [C_AXI_WIDTH-1:0] mem [C_MEM_DEPTH];
  logic [C_AXI_WIDTH-1:0] mem_rd_q;

  // Outputs stay quiet for one full cycle after reset release.
  logic [1:0] init_q;

  rstate_t       r_state_q, r_state_d;
  logic [AW-1:0] raddr_q;
  logic [7:0]    rlen_q, rcnt_q;
  logic          rsize_err_q, rerr_q;
  logic          rd_en, rlast_w, rd_size_err, rd_bad;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_off;

  wstate_t       w_state_q, w_state_d;
  logic [AW-1:0] waddr_q;
  logic [7:0]    wlen_q, wcnt_q;
  logic          wsize_err_q, werr_q;
  logic          aw_hs, w_hs, w_bad, wlast_w;
  logic [AW:0]   w_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_q <= 2'b00;
    else        init_q <= {init_q[0], 1'b1};
  end

  // Read-ahead: the array is read on the AR handshake and on every non-final R
  // handshake, so the registered output always holds the beat being presented.
  assign rlast_w     = (rcnt_q == rlen_q);
  assign rd_addr     = (r_state_q == R_IDLE) ? s_axi_araddr : raddr_q + STEP;
  assign rd_size_err = (r_state_q == R_IDLE) ? (s_axi_arsize != SIZE) : rsize_err_q;
  assign rd_off      = {1'b0, rd_addr} - {1'b0, C_BASE_ADDR};
  assign rd_bad      = rd_size_err || (rd_off >= LIMIT);

  always_comb begin
    r_state_d     = r_state_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    rd_en         = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = init_q[1];
        if (init_q[1] && s_axi_arvalid) begin
          rd_en     = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          if (rlast_w) r_state_d = R_IDLE;
          else         rd_en     = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s_axi_rlast = s_axi_rvalid && rlast_w;
  assign s_axi_rdata = (s_axi_rvalid && !rerr_q) ? mem_rd_q : '0;
  assign s_axi_rresp = (s_axi_rvalid && rerr_q) ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q   <= R_IDLE;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rcnt_q      <= '0;
      rsize_err_q <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (rd_en) begin
        raddr_q <= rd_addr;
        rerr_q  <= rd_bad;
        if (r_state_q == R_IDLE) begin
          rlen_q      <= s_axi_arlen;
          rcnt_q      <= 8'd0;
          rsize_err_q <= s_axi_arsize != SIZE;
        end else begin
          rcnt_q <= rcnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) mem_rd_q <= mem[rd_off[LOG2B +: MEM_AW]];
  end

  assign wlast_w = (wcnt_q == wlen_q);
  assign w_off   = {1'b0, waddr_q} - {1'b0, C_BASE_ADDR};
  assign w_bad   = wsize_err_q || (w_off >= LIMIT);

  always_comb begin
    w_state_d     = w_state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi_awready = init_q[1];
        if (init_q[1] && s_axi_awvalid) begin
          aw_hs     = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          w_hs = 1'b1;
          if (wlast_w) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi_bresp = (s_axi_bvalid && werr_q) ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q   <= W_IDLE;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      wsize_err_q <= 1'b0;
      werr_q      <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        waddr_q     <= s_axi_awaddr;
        wlen_q      <= s_axi_awlen;
        wcnt_q      <= 8'd0;
        wsize_err_q <= s_axi_awsize != SIZE;
        werr_q      <= 1'b0;
      end else if (w_hs) begin
        waddr_q <= waddr_q + STEP;
        wcnt_q  <= wcnt_q + 8'd1;
        // A misplaced wlast does not end the burst but does poison the response.
        werr_q  <= werr_q || w_bad || (s_axi_wlast != wlast_w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_bad) begin
      for (int b = 0; b < B; b++) begin
        if (s_axi_wstrb[b]) mem[w_off[LOG2B +: MEM_AW]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: stimulus tasks push expected R beats and B
// responses into queues; a negedge monitor pops and compares on each handshake.
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic [63:0] rdata;
  logic [1:0]  rresp, bresp;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready)
  );

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
    logic        l;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [63:0] model [1024];
  logic [63:0] wbuf [256];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] outs();
    return {arready, awready, wready, rvalid, rlast, bvalid, rdata, rresp, bresp};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (rq.size() == 0) begin
          total_cnt++;
          $display("FAIL rbeat: unexpected beat rdata=%h rresp=%b", rdata, rresp);
        end else begin
          chk("rbeat", {rdata, rresp, rlast}, {rq[0].d, rq[0].r, rq[0].l});
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          total_cnt++;
          $display("FAIL bresp: unexpected response %b", bresp);
        end else begin
          chk("bresp", bresp, bq.pop_front());
        end
      end
    end
  end

  task automatic reset_seq();
    rst_n = 1'b0;
    arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; rready = 0; bready = 0;
    #2;
    chk("reset_outputs", outs(), '0);
    rq.delete();
    bq.delete();
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_cycle1", outs(), '0);
    @(posedge clk);
    #1 chk("post_reset_cycle2_ready", {arready, awready}, 2'b11);
    $display("reset done");
  endtask

  task automatic push_model_read(input logic [31:0] addr, input int len, input logic [2:0] size);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      logic        ok;
      a  = addr + 32'(i * 8);
      ok = (size == 3'd3) && (a < 32'h2000);
      rq.push_back('{ok ? model[a[12:3]] : 64'd0, ok ? 2'b00 : 2'b10, i == len});
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [7:0] strb, input int wlast_at, input logic rnd,
                             input logic [1:0] exp_resp);
    logic ok, hs, done;
    int   n, beats;
    $display("write addr=%h len=%0d size=%0d strb=%h", addr, len, size, strb);
    bq.push_back(exp_resp);
    awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = awready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 100);
    awvalid = 1'b0;
    chk("aw_handshake", ok, 1'b1);
    beats = 0; n = 0;
    while (beats <= int'(len) && n < 2000) begin
      wdata = wbuf[beats]; wstrb = strb; wlast = (beats == wlast_at); wvalid = 1'b1;
      @(negedge clk); hs = wready;
      @(posedge clk); #1; n++;
      if (hs) begin
        logic [31:0] a;
        a = addr + 32'(beats * 8);
        if (size == 3'd3 && a < 32'h2000)
          for (int b = 0; b < 8; b++)
            if (strb[b]) model[a[12:3]][8*b +: 8] = wbuf[beats][8*b +: 8];
        beats++;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_beats", beats, int'(len) + 1);
    chk("w_to_resp", {wready, bvalid}, 2'b01);
    done = 0; n = 0;
    while (!done && n < 2000) begin
      bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); hs = bvalid && bready;
      @(posedge clk); #1; n++;
      if (hs) done = 1;
    end
    bready = 1'b0;
    chk("b_done", done, 1'b1);
    chk("awready_after_b", awready, 1'b1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic rnd, input int abort_at);
    logic ok, hs, last, done;
    int   n, beats, cycles;
    $display("read addr=%h len=%0d size=%0d", addr, len, size);
    araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = arready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 100);
    arvalid = 1'b0;
    chk("ar_handshake", ok, 1'b1);
    chk("rvalid_latency", {rvalid, arready}, 2'b10);
    beats = 0; cycles = 0; done = 0;
    while (!done && cycles < 4000) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); hs = rvalid && rready; last = rlast;
      @(posedge clk); #1; cycles++;
      if (hs) begin
        beats++;
        if (last) done = 1;
      end
      if (abort_at >= 0 && beats == abort_at) begin
        $display("reset asserted mid-read after %0d beats", beats);
        reset_seq();
        return;
      end
    end
    rready = 1'b0;
    chk("r_done", done, 1'b1);
    chk("r_beats", beats, int'(len) + 1);
    if (!rnd) chk("r_cycles", cycles, int'(len) + 1);
    chk("arready_after_r", arready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    reset_seq();

    // 4-beat write then read back of 1..4
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    write_burst(32'h0, 8'd3, 3'd3, 8'hFF, 3, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) rq.push_back('{64'(i + 1), 2'b00, i == 3});
    read_burst(32'h0, 8'd3, 3'd3, 1'b0, -1);

    // partial strobe merge
    wbuf[0] = 64'h11111111_22222222;
    write_burst(32'h100, 8'd0, 3'd3, 8'hFF, 0, 1'b0, 2'b00);
    wbuf[0] = 64'hAAAAAAAA_BBBBBBBB;
    write_burst(32'h100, 8'd0, 3'd3, 8'h0F, 0, 1'b0, 2'b00);
    rq.push_back('{64'h11111111_BBBBBBBB, 2'b00, 1'b1});
    read_burst(32'h100, 8'd0, 3'd3, 1'b0, -1);

    // last word, then a beat past the end of the array
    wbuf[0] = 64'hDEADBEEF_CAFEF00D;
    write_burst(32'h1FF8, 8'd0, 3'd3, 8'hFF, 0, 1'b0, 2'b00);
    rq.push_back('{64'hDEADBEEF_CAFEF00D, 2'b00, 1'b0});
    rq.push_back('{64'h0, 2'b10, 1'b1});
    read_burst(32'h1FF8, 8'd1, 3'd3, 1'b0, -1);

    // wrong arsize: all beats SLVERR
    for (int i = 0; i < 3; i++) rq.push_back('{64'h0, 2'b10, i == 2});
    read_burst(32'h0, 8'd2, 3'd2, 1'b0, -1);

    // early wlast: counter still takes 4 beats, response is SLVERR
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h5000 + 64'(i);
    write_burst(32'h200, 8'd3, 3'd3, 8'hFF, 1, 1'b0, 2'b10);
    push_model_read(32'h200, 3, 3'd3);
    read_burst(32'h200, 8'd3, 3'd3, 1'b0, -1);

    // out-of-range write
    wbuf[0] = 64'h1234;
    write_burst(32'h2000, 8'd0, 3'd3, 8'hFF, 0, 1'b0, 2'b10);

    // 256-beat bursts with random back-pressure
    for (int i = 0; i < 256; i++) wbuf[i] = {$urandom, $urandom};
    write_burst(32'h400, 8'd255, 3'd3, 8'hFF, 255, 1'b1, 2'b00);
    push_model_read(32'h400, 255, 3'd3);
    read_burst(32'h400, 8'd255, 3'd3, 1'b1, -1);

    // reset in the middle of a read burst
    push_model_read(32'h400, 255, 3'd3);
    read_burst(32'h400, 8'd255, 3'd3, 1'b1, 100);

    // array contents survive reset
    rq.push_back('{64'h1, 2'b00, 1'b1});
    read_burst(32'h0, 8'd0, 3'd3, 1'b0, -1);

    repeat (2) @(posedge clk);
    chk("queues_drained", rq.size() + bq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
